// File: rtl/power_domain_sequencer.sv
// power_domain_sequencer
// Sequences the power-gating controls of one switchable domain from the
// 2-bit power mode (ACTIVE=00, IDLE=01, SLEEP=10, 11 treated as ACTIVE).
// Power-down order: clock gate -> isolate -> retention save -> switch off.
// Power-up order:   switch on -> retention restore -> de-isolate -> clock on.
//
// Ports:
//   clk          in   block clock
//   rst          in   synchronous active-high reset
//   power_mode   in   [1:0] requested mode
//   pwr_ack      in   power-switch status (1 = rail up)
//   clk_en       out  domain clock enable
//   iso_en       out  output isolation enable
//   save         out  one-cycle retention save pulse
//   restore      out  one-cycle retention restore pulse
//   pwr_en       out  power-switch enable
//   domain_ready out  domain powered, de-isolated and clocked
//   seq_busy     out  power-down/up sequence in progress
//   timeout_err  out  sticky: switch ack not seen within ACK_TIMEOUT samples
//   seq_state    out  [3:0] current state encoding (debug)
module power_domain_sequencer #(
    parameter int STEP_CYCLES = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] power_mode,
    input  logic       pwr_ack,
    output logic       clk_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       pwr_en,
    output logic       domain_ready,
    output logic       seq_busy,
    output logic       timeout_err,
    output logic [3:0] seq_state
);

    localparam int MAXV = (STEP_CYCLES > ACK_TIMEOUT) ? STEP_CYCLES : ACK_TIMEOUT;
    localparam int CW   = (MAXV < 2) ? 1 : $clog2(MAXV + 1);

    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAXV);

    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_CG      = 4'd1,
        ST_ISO     = 4'd2,
        ST_SAVE    = 4'd3,
        ST_PDN     = 4'd4,
        ST_OFF     = 4'd5,
        ST_PUP     = 4'd6,
        ST_RESTORE = 4'd7,
        ST_DISO    = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic          to_set;

    logic mode_sleep, mode_idle, mode_active;
    assign mode_sleep  = (power_mode == 2'b10);
    assign mode_idle   = (power_mode == 2'b01);
    assign mode_active = (power_mode[1] == power_mode[0]);  // 00 or 11

    // In timed steps cnt_q counts cycles spent in the state; in PDN/PUP it
    // counts failed ack samples. It restarts from zero on every state entry.
    logic step_done;
    assign step_done = (cnt_q == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ON;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
            if (to_set)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        to_set       = 1'b0;
        clk_en       = 1'b0;
        iso_en       = 1'b0;
        pwr_en       = 1'b1;
        domain_ready = 1'b0;
        seq_busy     = 1'b0;
        save         = 1'b0;
        restore      = 1'b0;
        case (state_q)
            ST_ON: begin
                clk_en       = 1'b1;
                domain_ready = 1'b1;
                if (mode_idle || mode_sleep)
                    state_d = ST_CG;
            end
            ST_CG: begin
                if (mode_sleep)
                    state_d = ST_ISO;
                else if (mode_active)
                    state_d = ST_ON;
            end
            ST_ISO: begin
                iso_en   = 1'b1;
                seq_busy = 1'b1;
                if (step_done)
                    state_d = ST_SAVE;
            end
            ST_SAVE: begin
                iso_en   = 1'b1;
                seq_busy = 1'b1;
                save     = (cnt_q == '0);
                if (step_done)
                    state_d = ST_PDN;
            end
            ST_PDN: begin
                iso_en   = 1'b1;
                pwr_en   = 1'b0;
                seq_busy = 1'b1;
                if (!pwr_ack) begin
                    state_d = ST_OFF;
                end else if (cnt_q == ACK_LAST) begin
                    // Rail never reported down: flag it and treat it as off.
                    to_set  = 1'b1;
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                iso_en = 1'b1;
                pwr_en = 1'b0;
                if (!mode_sleep)
                    state_d = ST_PUP;
            end
            ST_PUP: begin
                iso_en   = 1'b1;
                seq_busy = 1'b1;
                if (pwr_ack)
                    state_d = ST_RESTORE;
                else if (cnt_q == ACK_LAST)
                    to_set = 1'b1;  // flag only; never restore an unpowered domain
            end
            ST_RESTORE: begin
                iso_en   = 1'b1;
                seq_busy = 1'b1;
                restore  = (cnt_q == '0);
                if (step_done)
                    state_d = ST_DISO;
            end
            ST_DISO: begin
                seq_busy = 1'b1;
                if (step_done)
                    state_d = ST_ON;
            end
            default: state_d = ST_ON;
        endcase
    end

    assign timeout_err = timeout_q;
    assign seq_state   = state_q;

endmodule
